// File: rtl/lfsr_checker.sv
// Receive-side checker for the Fibonacci LFSR pattern generator.
// It seeds from the incoming stream, locks after a run of correct predictions, then counts mismatches.
module lfsr_checker #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter int               LOCK_N = 16,
    parameter int               LOSS_N = 4,
    parameter int               ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int FW = $clog2(WIDTH + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           st, st_nxt;
    logic [WIDTH-1:0] s, s_nxt;
    logic [FW-1:0]    fill_cnt, fill_nxt;
    logic [7:0]       match_cnt, match_nxt;
    logic [7:0]       miss_cnt, miss_nxt;
    logic [ERR_W-1:0] err_base, err_nxt;
    logic             err_hit;
    logic             p, mis, seeded;

    assign p      = ^(s & TAPS);
    assign mis    = (in_bit != p);
    assign seeded = (fill_cnt == FW'(WIDTH));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            st        <= HUNT;
            s         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            st        <= st_nxt;
            s         <= s_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err_pulse <= err_hit;
            err_cnt   <= err_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        s_nxt     = s;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        err_hit   = 1'b0;
        if (in_valid) begin
            if (st == HUNT) begin
                s_nxt = {s[WIDTH-2:0], in_bit};
                if (!seeded) begin
                    fill_nxt = fill_cnt + FW'(1);
                end else if (!mis && s != '0) begin
                    // All-zero register never scores, so a stuck-0 line stays in HUNT
                    if (match_cnt == 8'(LOCK_N - 1)) begin
                        st_nxt    = LOCKED;
                        match_nxt = '0;
                        miss_nxt  = '0;
                    end else begin
                        match_nxt = match_cnt + 8'd1;
                    end
                end else begin
                    match_nxt = '0;
                end
            end else begin
                // Flywheel on our own prediction so line errors never corrupt s
                s_nxt = {s[WIDTH-2:0], p};
                if (mis) begin
                    err_hit = 1'b1;
                    if (miss_cnt == 8'(LOSS_N - 1)) begin
                        st_nxt    = HUNT;
                        fill_nxt  = '0;
                        match_nxt = '0;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_cnt + 8'd1;
                    end
                end else begin
                    miss_nxt = '0;
                end
            end
        end
        // Clear first, then count, so a coincident error leaves a count of one
        err_base = clr ? '0 : err_cnt;
        err_nxt  = (err_hit && err_base != '1) ? err_base + ERR_W'(1) : err_base;
    end

    assign locked = (st == LOCKED);

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench: directed scenarios plus random traffic against a recurrence-level model.
module tb_lfsr_checker;
    localparam int         W      = 4;
    localparam logic [3:0] TAPS   = 4'b1001;
    localparam int         LOCK_N = 4;
    localparam int         LOSS_N = 2;
    localparam int         ERR_W  = 8;
    localparam int         ERR_MAX = 255;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             clr = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // Generator history: g_hist[k] is the bit emitted k steps ago
    int g_hist[W];
    // Model: m_hist[k] is the bit the checker's register took k steps ago
    int m_hist[W];
    int m_fill, m_match, m_miss, m_locked, m_pulse, m_cnt;

    lfsr_checker #(
        .WIDTH(W), .TAPS(TAPS), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_bit(in_bit), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) m_hist[i] = 0;
        m_fill = 0; m_match = 0; m_miss = 0; m_locked = 0; m_pulse = 0; m_cnt = 0;
        for (int i = 0; i < W; i++) g_hist[i] = 0;
        g_hist[0] = 1;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        int pred, nz, x, err;
        pred = 0; nz = 0; err = 0; x = 0;
        for (int i = 0; i < W; i++) begin
            if (TAPS[i]) pred ^= m_hist[i];
            if (m_hist[i] != 0) nz = 1;
        end
        if (v) begin
            if (m_locked == 0) begin
                x = b;
                if (m_fill < W) m_fill++;
                else begin
                    if (b == pred && nz == 1) m_match++;
                    else m_match = 0;
                    if (m_match == LOCK_N) begin m_locked = 1; m_miss = 0; end
                end
            end else begin
                x = pred;
                if (b != pred) begin
                    err = 1;
                    m_miss++;
                    if (m_miss == LOSS_N) begin m_locked = 0; m_fill = 0; m_match = 0; end
                end else m_miss = 0;
            end
            for (int i = W - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = x;
        end
        if (c) m_cnt = 0;
        if (err == 1 && m_cnt < ERR_MAX) m_cnt++;
        m_pulse = err;
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        in_valid = v; in_bit = b; clr = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        check("locked", int'(locked), m_locked);
        check("err_pulse", int'(err_pulse), m_pulse);
        check("err_cnt", int'(err_cnt), m_cnt);
    endtask

    task automatic next_gen(output bit b);
        int acc;
        acc = 0;
        for (int i = 0; i < W; i++) if (TAPS[i]) acc ^= g_hist[i];
        for (int i = W - 1; i > 0; i--) g_hist[i] = g_hist[i-1];
        g_hist[0] = acc;
        b = acc[0];
    endtask

    task automatic send(input bit flip, input bit c);
        bit b;
        next_gen(b);
        step(1'b1, b ^ flip, c);
    endtask

    // Assert reset between clock edges and confirm outputs clear without a clock
    task automatic do_reset();
        in_valid = 1'b0; in_bit = 1'b0; clr = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_err_pulse", int'(err_pulse), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        bit seq[15];
        bit b;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Generator sequence from seed 0001
        seq = '{1,1,1,0,1,0,1,1,0,0,1,0,0,0,1};
        for (int i = 0; i < 15; i++) begin
            next_gen(b);
            check("gen_seq", int'(b), int'(seq[i]));
        end
        model_reset();

        // Clean stream: lock after 8 valid bits
        for (int i = 0; i < 7; i++) send(1'b0, 1'b0);
        check("no_lock_at7", int'(locked), 0);
        send(1'b0, 1'b0);
        check("lock_at8", int'(locked), 1);
        for (int i = 0; i < 60; i++) send(1'b0, 1'b0);
        check("clean_err_cnt", int'(err_cnt), 0);

        // Single inverted bit
        send(1'b1, 1'b0);
        check("single_pulse", int'(err_pulse), 1);
        check("single_cnt", int'(err_cnt), 1);
        send(1'b0, 1'b0);
        check("single_pulse_off", int'(err_pulse), 0);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
        check("single_still_locked", int'(locked), 1);
        check("single_cnt_hold", int'(err_cnt), 1);

        // Two consecutive bad bits drop lock, relock after 8 clean bits
        send(1'b1, 1'b0);
        check("dbl_locked_after1", int'(locked), 1);
        send(1'b1, 1'b0);
        check("dbl_unlocked", int'(locked), 0);
        check("dbl_cnt", int'(err_cnt), 3);
        for (int i = 0; i < 7; i++) send(1'b0, 1'b0);
        check("dbl_no_relock7", int'(locked), 0);
        send(1'b0, 1'b0);
        check("dbl_relock", int'(locked), 1);
        check("dbl_cnt_kept", int'(err_cnt), 3);

        // Stuck-0 line never locks
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
        check("zero_locked", int'(locked), 0);
        check("zero_cnt", int'(err_cnt), 0);

        // Alternating valid: lock counted in valid bits only
        do_reset();
        for (int i = 0; i < 7; i++) begin send(1'b0, 1'b0); step(1'b0, 1'b1, 1'b0); end
        check("gap_no_lock7", int'(locked), 0);
        send(1'b0, 1'b0);
        check("gap_lock8", int'(locked), 1);
        step(1'b0, 1'b0, 1'b0);
        check("gap_idle_hold", int'(locked), 1);

        // Saturation, clear, clear coincident with error, mid-stream reset
        do_reset();
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin send(1'b1, 1'b0); send(1'b0, 1'b0); end
        check("sat_cnt", int'(err_cnt), 255);
        check("sat_locked", int'(locked), 1);
        step(1'b0, 1'b0, 1'b1);
        check("clr_cnt", int'(err_cnt), 0);
        send(1'b1, 1'b1);
        check("clr_err_cnt", int'(err_cnt), 1);
        send(1'b0, 1'b0);
        do_reset();

        // Random traffic: gaps, injected errors and clears
        for (int i = 0; i < 3000; i++) begin
            bit v, f, c;
            v = ($urandom % 4) != 0;
            f = ($urandom % 16) == 0;
            c = ($urandom % 64) == 0;
            if (v) send(f, c);
            else step(1'b0, 1'($urandom % 2), c);
            if (($urandom % 1000) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
